tick_divider_chain: RTL and testbench
=====================================

// Module: tick_divider_chain
// PURPOSE
//  Parametrised clock-enable generator: a prescaler followed by a chain of decimal (or N-ary) stages.
//  Emits one single-cycle CE pulse per level, e.g. 1ms/10ms/100ms/1s from a 100MHz CLK.
//  Adds run/pause, synchronous restart and a runtime-reloadable prescaler period.
//  Feeds timers, debouncers and display-scan logic; all consumers stay on CLK.
// PARAMETERS
//  PRE_DIV    100000  reset prescaler period in CLK cycles (>=2); CE[0] period
//  PRE_W      17      prescaler counter/PRE_VAL width; must hold PRE_DIV-1
//  STAGES     3       number of chained stages after the prescaler (>=1)
//  STAGE_DIV  10      division ratio of every chained stage (>=2)
//  STAGE_W    4       stage counter width; must hold STAGE_DIV-1
// PORTS
//  CLK      in   1           clock, all logic on rising edge
//  RST      in   1           asynchronous, active-high reset
//  EN       in   1           1 = count; 0 = freeze all counters, all CE low
//  CLR      in   1           synchronous restart of all counters
//  LD       in   1           strobe: capture PRE_VAL as new prescaler reload value
//  PRE_VAL  in   PRE_W       new reload value; period = PRE_VAL+1 cycles
//  CE       out  STAGES+1    CE[0] prescaler tick; CE[k] = every STAGE_DIV^k ticks of CE[0]
// BEHAVIOUR
//  - Reset: reload reg = PRE_DIV-1, pre cnt = PRE_DIV-1, every stage cnt = STAGE_DIV-1; CE = 0.
//  - Prescaler: down-counter. When EN and cnt==0, reload from reload reg; else if EN, cnt-1.
//  - CE[0] = EN & (pre cnt==0): combinational from registers, exactly 1 cycle wide.
//  - Stage k (1..STAGES): decrements only on cycles with CE[k-1]=1; wraps 0 -> STAGE_DIV-1.
//  - CE[k] = CE[k-1] & (stage k cnt==0). All CEs that fire do so in the same cycle (aligned).
//  - First CE[0] occurs PRE_DIV EN-cycles after reset release; first CE[k] after PRE_DIV*STAGE_DIV^k.
//  - EN=0: counters hold value and CE=0; on EN return, counting resumes where it stopped (no lost or
//    extra ticks, only a delay).
//  - CLR (EN ignored): pre cnt <= reload reg; stages <= STAGE_DIV-1; CE=0 that cycle.
//    Next CE[0] occurs after reload+1 EN-cycles.
//  - LD: reload reg <= PRE_VAL; current count is untouched, new period applies from next wrap.
//  - LD & CLR same cycle: reload reg <= PRE_VAL and pre cnt <= PRE_VAL (new value used immediately).
//  - PRE_VAL=0: CE[0] high on every EN cycle after the current count expires; legal.
//  - Priority per cycle: RST > CLR > EN count; LD independent of EN.
//  - Arithmetic: unsigned; PRE_VAL is never truncated (width = PRE_W); no other wrap paths exist.
//  - RST mid-count: immediate return to reset values, CE drops asynchronously.
// STRUCTURE
//  - Shared header clock_defs.vh: default PRE_DIV/PRE_W for 100MHz build, sim-scale defaults
//    (PRE_DIV=10), STAGE_DIV=10.
//  - Sub-module tick_stage (STAGE_W, STAGE_DIV): one chained counter; ports CLK,RST,CLR,CE_IN,CE_OUT.
//  - Top: prescaler + reload reg + generate loop of STAGES tick_stage instances.
// TESTING (PRE_DIV=10, STAGES=2, STAGE_DIV=10, EN=1 unless stated)
//  1 Release RST at t0 -> CE[0] at cycles 10,20,..; CE[1] at 100,200; CE[2] at 1000,
//    with CE[0..2] all high there.
//  2 Drop EN for 7 cycles at count 4 -> no CE during pause; next CE[0] arrives exactly 7 cycles late.
//  3 LD with PRE_VAL=3 mid-period -> current period completes at 10; afterwards CE[0] every 4 cycles.
//  4 CLR+LD (PRE_VAL=1) same cycle at cycle 55 -> CE[0] at 57,59,..; CE[1] restarts, first at 55+20.
//  5 PRE_VAL=0 then CLR -> CE[0] on every EN cycle; CE[1] every 10 cycles; CE width always 1.
//  6 Assert RST at cycle 995 -> CE all 0 immediately; after release, first CE[2] at 1000 cycles.

Source files
------------

// File: rtl/tick_divider_chain_pkg.sv
// Shared build constants for the tick divider chain: full-rate (100 MHz) and
// sim-scale prescaler defaults, plus the default decimal stage ratio.
package tick_divider_chain_pkg;

  localparam int PRE_DIV_HW    = 100000;
  localparam int PRE_W_HW      = 17;
  localparam int PRE_DIV_SIM   = 10;
  localparam int PRE_W_SIM     = 4;
  localparam int STAGE_DIV_DEF = 10;
  localparam int STAGE_W_DEF   = 4;

endpackage

// File: rtl/tick_stage.sv
// One chained divider stage: counts CE_IN pulses down and passes through
// every STAGE_DIV-th one, aligned with the incoming pulse.
module tick_stage #(
  parameter int STAGE_W   = 4,
  parameter int STAGE_DIV = 10
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  input  logic CE_IN,
  output logic CE_OUT
);

  localparam logic [STAGE_W-1:0] CNT_TOP = STAGE_W'(STAGE_DIV - 1);

  logic [STAGE_W-1:0] cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= CNT_TOP;
    end else if (CLR) begin
      cnt_q <= CNT_TOP;
    end else if (CE_IN) begin
      cnt_q <= (cnt_q == '0) ? CNT_TOP : cnt_q - STAGE_W'(1);
    end
  end

  assign CE_OUT = CE_IN & (cnt_q == '0);

endmodule

// File: rtl/tick_divider_chain.sv
// Clock-enable generator: reloadable prescaler feeding a chain of tick_stage
// dividers; every CE output is a single-cycle pulse on CLK.
module tick_divider_chain
  import tick_divider_chain_pkg::*;
#(
  parameter int PRE_DIV   = PRE_DIV_HW,
  parameter int PRE_W     = PRE_W_HW,
  parameter int STAGES    = 3,
  parameter int STAGE_DIV = STAGE_DIV_DEF,
  parameter int STAGE_W   = STAGE_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic             LD,
  input  logic [PRE_W-1:0] PRE_VAL,
  output logic [STAGES:0]  CE
);

  localparam logic [PRE_W-1:0] PRE_RST = PRE_W'(PRE_DIV - 1);

  logic [PRE_W-1:0] reload_q;
  logic [PRE_W-1:0] pre_cnt_q;

  // Reload value changes never disturb the running count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      reload_q <= PRE_RST;
    end else if (LD) begin
      reload_q <= PRE_VAL;
    end
  end

  // A restart coinciding with a load takes the new value straight away.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_cnt_q <= PRE_RST;
    end else if (CLR) begin
      pre_cnt_q <= LD ? PRE_VAL : reload_q;
    end else if (EN) begin
      pre_cnt_q <= (pre_cnt_q == '0) ? reload_q : pre_cnt_q - PRE_W'(1);
    end
  end

  assign CE[0] = EN & ~CLR & (pre_cnt_q == '0);

  genvar k;
  generate
    for (k = 1; k <= STAGES; k++) begin : g_stage
      tick_stage #(
        .STAGE_W   (STAGE_W),
        .STAGE_DIV (STAGE_DIV)
      ) u_stage (
        .CLK    (CLK),
        .RST    (RST),
        .CLR    (CLR),
        .CE_IN  (CE[k-1]),
        .CE_OUT (CE[k])
      );
    end
  endgenerate

endmodule

// File: tb/tb_tick_divider_chain.sv
// Directed bench for tick_divider_chain at sim scale (period 10, two decimal
// stages); expected CE patterns are worked out per cycle from the timing rules.
module tb_tick_divider_chain;
  import tick_divider_chain_pkg::*;

  localparam int PRE_DIV   = PRE_DIV_SIM;
  localparam int PRE_W     = PRE_W_SIM;
  localparam int STAGES    = 2;
  localparam int STAGE_DIV = STAGE_DIV_DEF;
  localparam int STAGE_W   = STAGE_W_DEF;

  logic              clk_r   = 1'b0;
  logic              rst_r   = 1'b1;
  logic              en_r    = 1'b0;
  logic              clr_r   = 1'b0;
  logic              ld_r    = 1'b0;
  logic [PRE_W-1:0]  pre_val = '0;
  logic [STAGES:0]   ce;
  logic [STAGES:0]   exp_v;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  tick_divider_chain #(
    .PRE_DIV   (PRE_DIV),
    .PRE_W     (PRE_W),
    .STAGES    (STAGES),
    .STAGE_DIV (STAGE_DIV),
    .STAGE_W   (STAGE_W)
  ) dut (
    .CLK     (clk_r),
    .RST     (rst_r),
    .EN      (en_r),
    .CLR     (clr_r),
    .LD      (ld_r),
    .PRE_VAL (pre_val),
    .CE      (ce)
  );

  // clock / reset block
  always #5 clk_r = ~clk_r;

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

  task automatic check_vec(input string tag, input logic [STAGES:0] got,
                           input logic [STAGES:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  // Cycle n is the interval just before the n-th rising edge after release.
  task automatic tick();
    @(posedge clk_r);
    #2;
    cyc++;
  endtask

  task automatic sample(input string tag, input logic [STAGES:0] exp);
    #1;
    check_vec(tag, ce, exp);
  endtask

  task automatic do_reset();
    rst_r   = 1'b1;
    en_r    = 1'b1;
    clr_r   = 1'b0;
    ld_r    = 1'b0;
    pre_val = '0;
    repeat (2) @(posedge clk_r);
    #2;
    check_vec("reset_ce", ce, '0);
    rst_r = 1'b0;
    cyc   = 1;
  endtask

  // CE pattern for e effective counting cycles at the default period.
  function automatic logic [STAGES:0] ce_exp(input int e);
    logic [STAGES:0] r;
    r[0] = (e > 0) && (e % 10 == 0);
    r[1] = (e > 0) && (e % 100 == 0);
    r[2] = (e > 0) && (e % 1000 == 0);
    return r;
  endfunction

  initial begin
    // free run from reset, then asynchronous drop while all CEs are high
    do_reset();
    for (int c = 1; c <= 1000; c++) begin
      sample("free_run", ce_exp(c));
      if (c < 1000) tick();
    end
    #1 rst_r = 1'b1;
    #1 check_vec("rst_async_drop", ce, '0);

    // reset at cycle 995, then a full fresh run
    do_reset();
    for (int c = 1; c <= 995; c++) begin
      sample("pre_rst_995", ce_exp(c));
      if (c < 995) tick();
    end
    #1 rst_r = 1'b1;
    #1 check_vec("rst_995_drop", ce, '0);
    do_reset();
    for (int c = 1; c <= 1000; c++) begin
      sample("after_rst", ce_exp(c));
      tick();
    end

    // pause for 7 cycles while the prescaler holds 4
    do_reset();
    for (int c = 1; c <= 110; c++) begin
      int e;
      en_r = !(c >= 6 && c <= 12);
      e = (c < 6) ? c : ((c <= 12) ? 0 : c - 7);
      sample("en_pause", (c >= 6 && c <= 12) ? '0 : ce_exp(e));
      tick();
    end
    en_r = 1'b1;

    // load period 4 mid-period: the running period still ends at 10
    do_reset();
    pre_val = 4'd3;
    for (int c = 1; c <= 90; c++) begin
      int n;
      ld_r = (c == 5);
      n = (c - 10) / 4 + 1;
      exp_v    = '0;
      exp_v[0] = (c == 10) || (c > 10 && (c - 10) % 4 == 0);
      exp_v[1] = exp_v[0] && (n % 10 == 0);
      sample("ld_mid", exp_v);
      tick();
    end
    ld_r = 1'b0;

    // restart with simultaneous load of period 2 at cycle 55
    do_reset();
    pre_val = 4'd1;
    for (int c = 1; c <= 100; c++) begin
      clr_r = (c == 55);
      ld_r  = (c == 55);
      if (c < 55) begin
        exp_v = ce_exp(c);
      end else begin
        exp_v    = '0;
        exp_v[0] = (c > 55) && ((c - 55) % 2 == 0);
        exp_v[1] = (c > 55) && ((c - 55) % 20 == 0);
      end
      sample("clr_ld", exp_v);
      tick();
    end
    clr_r = 1'b0;
    ld_r  = 1'b0;

    // reload 0, then restart on a cycle where CE[0] would otherwise fire
    do_reset();
    pre_val = '0;
    for (int c = 1; c <= 120; c++) begin
      ld_r  = (c == 3);
      clr_r = (c == 10);
      exp_v = '0;
      if (c > 10) begin
        exp_v[0] = 1'b1;
        exp_v[1] = ((c - 10) % 10 == 0);
        exp_v[2] = ((c - 10) % 100 == 0);
      end
      sample("pre_val_zero", exp_v);
      tick();
    end
    ld_r  = 1'b0;
    clr_r = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
